// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM, condition unit and NZCV register for the multicycle ARM datapath
module multicycle_controller #(
  parameter bit NV_ALWAYS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, nextState;
  logic       condEx;
  logic       condTrue;
  logic       noWrite;
  logic       inExec;
  logic       isRd15;
  logic [1:0] aluDec;
  logic [3:0] flags;

  assign inExec = (state == EXECR) || (state == EXECI);
  assign isRd15 = (Rd == 4'd15);
  assign Flags  = flags;
  assign State  = state;

  // Condition code check against the flag register ({N,Z,C,V})
  always_comb begin
    condTrue = 1'b0;
    case (Cond)
      4'b0000: condTrue = flags[2];
      4'b0001: condTrue = ~flags[2];
      4'b0010: condTrue = flags[1];
      4'b0011: condTrue = ~flags[1];
      4'b0100: condTrue = flags[3];
      4'b0101: condTrue = ~flags[3];
      4'b0110: condTrue = flags[0];
      4'b0111: condTrue = ~flags[0];
      4'b1000: condTrue = flags[1] & ~flags[2];
      4'b1001: condTrue = ~flags[1] | flags[2];
      4'b1010: condTrue = (flags[3] == flags[0]);
      4'b1011: condTrue = (flags[3] != flags[0]);
      4'b1100: condTrue = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condTrue = flags[2] | (flags[3] != flags[0]);
      4'b1110: condTrue = 1'b1;
      default: condTrue = NV_ALWAYS;
    endcase
  end

  // Data-processing cmd decode; unsupported commands add but never write back
  always_comb begin
    aluDec  = 2'b00;
    noWrite = 1'b0;
    case (Funct[4:1])
      4'b0100: aluDec = 2'b00;
      4'b0010: aluDec = 2'b01;
      4'b0000: aluDec = 2'b10;
      4'b1100: aluDec = 2'b11;
      4'b1010: begin aluDec = 2'b01; noWrite = 1'b1; end
      default: begin aluDec = 2'b00; noWrite = 1'b1; end
    endcase
  end

  // State register; CondEx is captured leaving DECODE so later flag updates cannot affect it
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      condEx <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DECODE) condEx <= condTrue;
    end
  end

  // NZCV update at the end of an executed S-suffixed data-processing op; logical ops keep C and V
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (inExec && Funct[0] && condEx) begin
      flags[3:2] <= ALUFlags[3:2];
      if (!aluDec[1]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Next-state and per-state datapath controls; reset masks every enable and shows FETCH selects
  always_comb begin
    nextState  = FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = Op;
    RegSrc     = {(Op == 2'b01) && !Funct[0], (Op == 2'b10)};
    if (reset) begin
      ALUSrcA   = 2'b01;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state)
        FETCH: begin
          nextState = DECODE;
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          case (Op)
            2'b01:   nextState = MEMADR;
            2'b00:   nextState = Funct[5] ? EXECI : EXECR;
            2'b10:   nextState = BRANCH;
            default: nextState = FETCH;
          endcase
        end
        MEMADR: begin
          nextState = Funct[0] ? MEMREAD : MEMWRITE;
          ALUSrcB   = 2'b01;
        end
        MEMREAD: begin
          nextState = MEMWB;
          AdrSrc    = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = condEx;
          PCWrite   = condEx & isRd15;
        end
        MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = condEx;
        end
        EXECR: begin
          nextState  = ALUWB;
          ALUControl = aluDec;
        end
        EXECI: begin
          nextState  = ALUWB;
          ALUSrcB    = 2'b01;
          ALUControl = aluDec;
        end
        ALUWB: begin
          RegWrite = condEx & ~noWrite;
          PCWrite  = condEx & isRd15 & ~noWrite;
        end
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = condEx;
        end
        default: nextState = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;

  int checks = 0;
  int failures = 0;

  logic [3:0] es, ws, fl;
  logic [1:0] ac;
  logic       rw, pw;

  multicycle_controller #(.NV_ALWAYS(1'b0)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to the middle of the next clock cycle (just after the falling edge)
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
    #1;
  endtask

  // Run one data-processing instruction from FETCH back to FETCH, capturing what it did
  task automatic runDp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    setInstr(c, 2'b00, f, r);
    cyc();
    cyc();
    ALUFlags = af;
    #1;
    es = State; ac = ALUControl;
    cyc();
    ALUFlags = 4'b0000;
    #1;
    ws = State; rw = RegWrite; pw = PCWrite;
    cyc();
    fl = Flags;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", State); end
    checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", Flags); end
    checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin failures++; $display("FAIL rst_enables got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
    cyc();
    checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin failures++; $display("FAIL rst_enables2 got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
    checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 6'b011010) begin failures++; $display("FAIL rst_selects got=%b exp=011010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    cyc();
    reset = 1'b0;
    setInstr(4'b1110, 2'b11, 6'b000000, 4'd0);
    checks++; if ({State, IRWrite, PCWrite} !== 6'b000011) begin failures++; $display("FAIL first_fetch got=%b exp=000011", {State, IRWrite, PCWrite}); end
    cyc();
    checks++; if (State !== 4'd1) begin failures++; $display("FAIL nop_decode got=%0d exp=1", State); end
    cyc();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL nop_return got=%0d exp=0", State); end
  endtask

  task automatic test_add_imm();
    setInstr(4'b1110, 2'b00, 6'b101000, 4'd3);
    cyc();
    checks++; if ({State, ALUSrcA, ALUSrcB, ResultSrc, RegWrite} !== 11'b0001_01_10_10_0) begin failures++; $display("FAIL add_decode got=%b exp=00010110100", {State, ALUSrcA, ALUSrcB, ResultSrc, RegWrite}); end
    cyc();
    ALUFlags = 4'b1111;
    #1;
    checks++; if ({State, ALUControl, ALUSrcB, RegWrite} !== 9'b0111_00_01_0) begin failures++; $display("FAIL add_execi got=%b exp=011100010", {State, ALUControl, ALUSrcB, RegWrite}); end
    cyc();
    ALUFlags = 4'b0000;
    #1;
    checks++; if ({State, RegWrite, PCWrite} !== 6'b1000_1_0) begin failures++; $display("FAIL add_aluwb got=%b exp=100010", {State, RegWrite, PCWrite}); end
    cyc();
    checks++; if ({State, Flags} !== 8'b0000_0000) begin failures++; $display("FAIL add_end got=%b exp=00000000", {State, Flags}); end
  endtask

  task automatic test_cmp();
    runDp(4'b1110, 6'b010101, 4'd15, 4'b0110);
    checks++; if ({es, ac} !== 6'b0110_01) begin failures++; $display("FAIL cmp_execr got=%b exp=011001", {es, ac}); end
    checks++; if ({ws, rw, pw} !== 6'b1000_0_0) begin failures++; $display("FAIL cmp_aluwb got=%b exp=100000", {ws, rw, pw}); end
    checks++; if (fl !== 4'b0110) begin failures++; $display("FAIL cmp_flags got=%b exp=0110", fl); end
  endtask

  task automatic test_cond();
    runDp(4'b1110, 6'b010101, 4'd0, 4'b0100);
    checks++; if (fl !== 4'b0100) begin failures++; $display("FAIL cond_setz got=%b exp=0100", fl); end
    runDp(4'b0001, 6'b101000, 4'd2, 4'b0000);
    checks++; if (rw !== 1'b0) begin failures++; $display("FAIL cond_ne got=%b exp=0", rw); end
    runDp(4'b0000, 6'b101000, 4'd2, 4'b0000);
    checks++; if (rw !== 1'b1) begin failures++; $display("FAIL cond_eq got=%b exp=1", rw); end
    runDp(4'b1110, 6'b000001, 4'd4, 4'b1011);
    checks++; if ({ac, rw, fl} !== 7'b10_1_1000) begin failures++; $display("FAIL ands got=%b exp=1011000", {ac, rw, fl}); end
    runDp(4'b0000, 6'b101001, 4'd5, 4'b0111);
    checks++; if ({rw, fl} !== 5'b0_1000) begin failures++; $display("FAIL adds_skipped got=%b exp=01000", {rw, fl}); end
    runDp(4'b1110, 6'b011000, 4'd6, 4'b0000);
    checks++; if ({ac, rw, fl} !== 7'b11_1_1000) begin failures++; $display("FAIL orr got=%b exp=1111000", {ac, rw, fl}); end
    runDp(4'b1110, 6'b000010, 4'd15, 4'b0000);
    checks++; if ({ac, rw, pw} !== 4'b00_0_0) begin failures++; $display("FAIL bad_cmd got=%b exp=0000", {ac, rw, pw}); end
    runDp(4'b1111, 6'b101000, 4'd1, 4'b0000);
    checks++; if (rw !== 1'b0) begin failures++; $display("FAIL cond_nv got=%b exp=0", rw); end
    runDp(4'b1010, 6'b101000, 4'd15, 4'b0000);
    checks++; if ({rw, pw} !== 2'b00) begin failures++; $display("FAIL cond_ge got=%b exp=00", {rw, pw}); end
    runDp(4'b1011, 6'b101000, 4'd15, 4'b0000);
    checks++; if ({rw, pw} !== 2'b11) begin failures++; $display("FAIL cond_lt got=%b exp=11", {rw, pw}); end
  endtask

  task automatic test_mem();
    setInstr(4'b1110, 2'b01, 6'b000001, 4'd15);
    checks++; if ({RegSrc, ImmSrc} !== 4'b00_01) begin failures++; $display("FAIL ldr_src got=%b exp=0001", {RegSrc, ImmSrc}); end
    cyc();
    cyc();
    checks++; if ({State, ALUSrcA, ALUSrcB, ALUControl} !== 10'b0010_00_01_00) begin failures++; $display("FAIL ldr_memadr got=%b exp=0010000100", {State, ALUSrcA, ALUSrcB, ALUControl}); end
    cyc();
    checks++; if ({State, AdrSrc, MemWrite, RegWrite} !== 7'b0011_1_0_0) begin failures++; $display("FAIL ldr_memread got=%b exp=0011100", {State, AdrSrc, MemWrite, RegWrite}); end
    cyc();
    checks++; if ({State, ResultSrc, RegWrite, PCWrite} !== 8'b0100_01_1_1) begin failures++; $display("FAIL ldr_memwb got=%b exp=01000111", {State, ResultSrc, RegWrite, PCWrite}); end
    cyc();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL ldr_end got=%0d exp=0", State); end
    setInstr(4'b1110, 2'b01, 6'b000000, 4'd7);
    checks++; if (RegSrc !== 2'b10) begin failures++; $display("FAIL str_regsrc got=%b exp=10", RegSrc); end
    cyc();
    cyc();
    checks++; if (State !== 4'd2) begin failures++; $display("FAIL str_memadr got=%0d exp=2", State); end
    cyc();
    checks++; if ({State, AdrSrc, MemWrite, RegWrite} !== 7'b0101_1_1_0) begin failures++; $display("FAIL str_memwrite got=%b exp=0101110", {State, AdrSrc, MemWrite, RegWrite}); end
    cyc();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL str_end got=%0d exp=0", State); end
  endtask

  task automatic test_branch();
    runDp(4'b1110, 6'b010101, 4'd0, 4'b0010);
    checks++; if (fl !== 4'b0010) begin failures++; $display("FAIL br_setc got=%b exp=0010", fl); end
    setInstr(4'b1001, 2'b10, 6'b100000, 4'd0);
    checks++; if ({RegSrc, ImmSrc} !== 4'b01_10) begin failures++; $display("FAIL br_src got=%b exp=0110", {RegSrc, ImmSrc}); end
    cyc();
    cyc();
    checks++; if ({State, PCWrite, ALUSrcB, ResultSrc} !== 9'b1001_0_01_10) begin failures++; $display("FAIL br_ls got=%b exp=100100110", {State, PCWrite, ALUSrcB, ResultSrc}); end
    cyc();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL br_end got=%0d exp=0", State); end
    setInstr(4'b1000, 2'b10, 6'b100000, 4'd0);
    cyc();
    cyc();
    checks++; if ({State, PCWrite} !== 5'b1001_1) begin failures++; $display("FAIL br_hi got=%b exp=10011", {State, PCWrite}); end
    cyc();
  endtask

  task automatic test_reset_mid();
    setInstr(4'b1110, 2'b00, 6'b001000, 4'd15);
    cyc();
    cyc();
    checks++; if (State !== 4'd6) begin failures++; $display("FAIL mid_execr got=%0d exp=6", State); end
    reset = 1'b1;
    #1;
    checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc} !== 10'b0000_01_10_10) begin failures++; $display("FAIL mid_rst_outs got=%b exp=0000011010", {PCWrite, IRWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc}); end
    cyc();
    checks++; if ({State, RegWrite, PCWrite, Flags} !== 10'b0000_0_0_0000) begin failures++; $display("FAIL mid_rst_state got=%b exp=0000000000", {State, RegWrite, PCWrite, Flags}); end
    reset = 1'b0;
    setInstr(4'b1110, 2'b11, 6'b000000, 4'd0);
    checks++; if ({State, IRWrite, PCWrite} !== 6'b0000_1_1) begin failures++; $display("FAIL mid_refetch got=%b exp=000011", {State, IRWrite, PCWrite}); end
    cyc();
    checks++; if ({State, RegWrite} !== 5'b0001_0) begin failures++; $display("FAIL mid_decode got=%b exp=00010", {State, RegWrite}); end
    cyc();
  endtask

  initial begin
    reset = 1'b1; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    test_reset();
    test_add_imm();
    test_cmp();
    test_cond();
    test_mem();
    test_branch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit that sequences a shared-ALU, single-memory multicycle ARM datapath. One ALU, one memory port, one register file are reused across states.
- Decodes the latched instruction fields (Cond, Op, Funct, Rd), holds the NZCV flag register and evaluates condition codes.
- Every cycle it drives the mux selects and write enables for the datapath. It replaces the single-cycle decoder in the multicycle build of the calculator.

Parameters:
NV_ALWAYS, 0, behaviour of Cond=1111: 0 means never execute, 1 means always execute.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
Cond  input  4  instruction bits [31:28].
Op  input  2  instruction bits [27:26].
Funct  input  6  instruction bits [25:20]: I, cmd[3:0], S/L.
Rd  input  4  instruction bits [15:12].
ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
PCWrite  output  1  PC register enable.
IRWrite  output  1  instruction register enable.
MemWrite  output  1  data memory write enable.
RegWrite  output  1  register file write enable.
AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register.
ResultSrc  output  2  result select: 00=ALUOut register, 01=read data, 10=ALU direct.
ALUSrcA  output  2  ALU A select: 00=RD1, 01=PC.
ALUSrcB  output  2  ALU B select: 00=RD2, 01=extended immediate, 10=constant 4.
ImmSrc  output  2  equal to Op.
RegSrc  output  2  [0]=1 when Op=10 (read R15); [1]=1 when Op=01 and L=0 (STR reads Rd).
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
Flags  output  4  current NZCV register.
State  output  4  current FSM state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 go to FETCH.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE: Op=01 goes to MEMADR. Op=00 goes to EXECI if Funct[5]=1, otherwise EXECR. Op=10 goes to BRANCH. Op=11 goes to FETCH (NOP).
  - MEMADR: L=1 goes to MEMREAD, L=0 goes to MEMWRITE.
  - MEMREAD goes to MEMWB. EXECR and EXECI go to ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH go to FETCH.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, Op=11 2.
- Per-state outputs (unlisted enables are 0; unlisted selects are 00):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. This forms PC+8 for R15 reads.
  - MEMADR: ALUSrcB=01, ALUControl=ADD. Funct[3] (U) is ignored; offsets are positive only.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01. RegWrite=CondEx. PCWrite=CondEx when Rd=15.
  - MEMWRITE: AdrSrc=1, MemWrite=CondEx.
  - EXECR / EXECI: ALUSrcB=00 / 01. ALUControl is decoded from cmd.
  - ALUWB: RegWrite=CondEx & ~NoWrite. PCWrite=CondEx & (Rd=15) & ~NoWrite.
  - BRANCH: ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1). Any other cmd decodes as ADD with NoWrite=1.
- Condition codes, evaluated on the Flags register:
  - EQ Z, NE !Z, CS C, CC !C.
  - MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1. NV per the NV_ALWAYS parameter.
- CondEx timing: registered at the DECODE→next edge and held for the rest of the instruction. A flag update in EXEC therefore does not alter the same instruction's writeback.
- Flag update:
  - At the end of EXECR/EXECI, if S=1 and CondEx=1, N and Z load from ALUFlags.
  - C and V also load only when ALUControl is ADD or SUB. For AND/ORR they are preserved.
  - Flags never change in any other state.
- Reset:
  - On a clk edge with reset=1: State←FETCH, Flags←0000, CondEx←0.
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Selects show the FETCH encoding.
  - Reset asserted mid-instruction abandons it: no write enable fires in that cycle. The first fetch happens in the cycle after reset deasserts.
- Cond, Op, Funct and Rd are sampled from the IR. They are stable from DECODE to the end of the instruction. The controller relies on IRWrite=1 only in FETCH.

Test Plan:
1. Reset high for 2 cycles, then low → State=0, Flags=0000, all enables 0 during reset. The first post-reset cycle shows IRWrite=1 and PCWrite=1.
2. Op=00, Funct=101000 (ADD imm), Cond=1110 → states 0,1,7,8 in sequence. ALUControl=00 in EXECI; RegWrite=1 only in ALUWB; Flags unchanged.
3. Op=00, Funct=010101 (CMP), Cond=1110, ALUFlags=0110 during EXECR → Flags=0110 after EXECR. ALUWB has RegWrite=0 and PCWrite=0.
4. Flags=0100 (Z). ADD with Cond=0001 (NE) → ALUWB RegWrite=0. The same instruction with Cond=0000 (EQ) → RegWrite=1.
5. Op=01, Funct=000001 (LDR), Cond=1110, Rd=15 → states 0,1,2,3,4. MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1, PCWrite=1. Repeat with Funct=000000 (STR) → 0,1,2,5 with MemWrite=1 in MEMWRITE and RegSrc=10.
6. Op=10, Funct=100000, Cond=1001, Flags=0010 (C, !Z) → LS is false, PCWrite=0 in BRANCH. Assert reset during EXECR of an ADD → no RegWrite pulse; FSM restarts at FETCH.
